alu_cmd_sequencer: RTL and testbench

- Upstream issue stage for the ALU593 datapath.
- Accepts ALU commands (op, A, B) over a valid/ready interface and buffers them in a small FIFO.
- Issues each command to the ALU with a one-cycle `start` pulse, holds operands stable until the ALU's `done`, then presents the 16-bit result downstream over a valid/ready response interface.
- Completes NOP and reserved opcodes locally without occupying the ALU.

---
 rtl/alu_cmd_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_sequencer
// Purpose  : Command FIFO plus single-issue sequencer for the ALU593 datapath.
//            Optional macro ALU_SEQ_TIMEOUT_EN aborts a stalled ALU command.
// Revision : 1.0  initial release
// ============================================================================
module alu_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [3:0]             cmd_op,
    input  logic [7:0]             cmd_a,
    input  logic [7:0]             cmd_b,
    output logic [3:0]             alu_op,
    output logic [7:0]             alu_a,
    output logic [7:0]             alu_b,
    output logic                   alu_start,
    input  logic                   alu_done,
    input  logic [15:0]            alu_result,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [15:0]            rsp_data,
    output logic [3:0]             rsp_op,
    output logic                   rsp_err,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   busy
);

    localparam int                 c_PTR_W        = $clog2(DEPTH);
    localparam int                 c_CNT_W        = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL         = c_CNT_W'(DEPTH);
    localparam logic [15:0]        c_TIMEOUT_DATA = 16'hDEAD;

    // DEPTH must be a power of two so the pointers wrap naturally
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_params
        $error("alu_cmd_sequencer: illegal DEPTH or TIMEOUT");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [19:0]        r_fifo_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic [3:0]         r_op;
    logic [7:0]         r_a;
    logic [7:0]         r_b;
    logic [15:0]        r_rsp_data;
    logic               r_rsp_err;

    logic               w_push;
    logic               w_pop;
    logic               w_timeout;
    logic [19:0]        w_head;
    logic               w_head_alu;
    logic               w_head_rsvd;

    assign w_push      = cmd_valid && cmd_ready;
    assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
    assign w_head      = r_fifo_mem[r_rd_ptr];
    assign w_head_alu  = (w_head[19:16] >= 4'd1)  && (w_head[19:16] <= 4'd9);
    assign w_head_rsvd = (w_head[19:16] >= 4'd10) && (w_head[19:16] <= 4'd14);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= {cmd_op, cmd_a, cmd_b};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_wait_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    // A done arriving in the final WAIT cycle still takes priority
    assign w_timeout = (r_state == S_WAIT) && !alu_done && (r_wait_cnt == c_WAIT_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                {r_op, r_a, r_b} <= w_head;
                r_rsp_data       <= '0;
                r_rsp_err        <= w_head_rsvd;
            end else if (r_state == S_WAIT) begin
                if (alu_done) begin
                    r_rsp_data <= alu_result;
                    r_rsp_err  <= 1'b0;
                end else if (w_timeout) begin
                    r_rsp_data <= c_TIMEOUT_DATA;
                    r_rsp_err  <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        alu_start   = 1'b0;
        alu_op      = '0;
        alu_a       = '0;
        alu_b       = '0;
        rsp_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_state_nxt = w_head_alu ? S_ISSUE : S_OUT;
                end
            end
            S_ISSUE: begin
                alu_start   = 1'b1;
                alu_op      = r_op;
                alu_a       = r_a;
                alu_b       = r_b;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                alu_op = r_op;
                alu_a  = r_a;
                alu_b  = r_b;
                if (alu_done || w_timeout) begin
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign cmd_ready  = (r_count < c_FULL);
    assign fifo_count = r_count;
    assign rsp_data   = r_rsp_data;
    assign rsp_op     = r_op;
    assign rsp_err    = r_rsp_err;
    assign busy       = (r_state != S_IDLE) || (r_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_sequencer
// Purpose  : Directed self-checking bench for alu_cmd_sequencer with a
//            response scoreboard and a behavioural ALU with settable latency.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_cmd_sequencer;

    localparam int c_DEPTH   = 4;
    localparam int c_TIMEOUT = 15;

    typedef struct packed {
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] data;
        logic        err;
    } cmd_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [3:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_start;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_op;
    logic        rsp_err;
    logic [2:0]  fifo_count;
    logic        busy;

    int          n_checks = 0;
    int          n_err    = 0;
    int          n_starts = 0;
    int          alu_delay = 1;
    bit          alu_never = 1'b0;
    int          pending   = 0;
    cmd_t        exp_rsp[$];
    cmd_t        exp_issue[$];
    logic [15:0] got[$];

    logic [3:0]  local_ops [3] = '{4'h0, 4'hC, 4'hF};
    logic        local_err [3] = '{1'b0, 1'b1, 1'b0};

    alu_cmd_sequencer #(.DEPTH(c_DEPTH), .TIMEOUT(c_TIMEOUT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_start  (alu_start),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_op     (rsp_op),
        .rsp_err    (rsp_err),
        .fifo_count (fifo_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd1:    return 16'(a) + 16'(b);
            4'd2:    return 16'(a) - 16'(b);
            4'd3:    return 16'(a) * 16'(b);
            4'd4:    return {8'h00, a & b};
            4'd5:    return {8'h00, a | b};
            4'd6:    return {8'h00, a ^ b};
            default: return {a, b};
        endcase
    endfunction

    function automatic bit is_alu(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd9);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        cmd_t c;
        bit   accepted;
        accepted = 1'b0;
        c.op = op;
        c.a  = a;
        c.b  = b;
        if (is_alu(op)) begin
            c.data = alu_model(op, a, b);
            c.err  = 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
            if (alu_never || alu_delay > c_TIMEOUT) begin
                c.data = 16'hDEAD;
                c.err  = 1'b1;
            end
`endif
        end else begin
            c.data = 16'h0000;
            c.err  = (op >= 4'd10) && (op <= 4'd14);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        for (int i = 0; i < 50 && !accepted; i++) begin
            if (cmd_ready) begin
                exp_rsp.push_back(c);
                if (is_alu(op)) exp_issue.push_back(c);
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        chk("push_accepted", 32'(accepted), 1);
    endtask

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        while ((exp_rsp.size() != 0 || busy) && i < budget) begin
            step(1);
            i++;
        end
        chk("drain_in_budget", 32'(exp_rsp.size() == 0 && !busy), 1);
    endtask

    // Behavioural ALU: done arrives alu_delay cycles after the start pulse
    initial begin
        logic [3:0] s_op;
        logic [7:0] s_a;
        logic [7:0] s_b;
        s_op       = '0;
        s_a        = '0;
        s_b        = '0;
        alu_done   = 1'b0;
        alu_result = 16'h5A5A;
        forever begin
            @(posedge clk);
            #1;
            alu_done   = 1'b0;
            alu_result = 16'h5A5A;
            if (pending > 0) begin
                pending--;
                if (pending == 0) begin
                    alu_done   = 1'b1;
                    alu_result = alu_model(s_op, s_a, s_b);
                end
            end
            if (alu_start && reset_n && !alu_never) begin
                s_op    = alu_op;
                s_a     = alu_a;
                s_b     = alu_b;
                pending = alu_delay;
            end
        end
    end

    // Compare process: issue order, operand stability, response order and hold
    initial begin
        cmd_t        it;
        cmd_t        e;
        logic [19:0] issued;
        logic [20:0] held;
        bit          inflight;
        bit          prev_hold;
        inflight  = 1'b0;
        prev_hold = 1'b0;
        issued    = '0;
        held      = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                inflight  = 1'b0;
                prev_hold = 1'b0;
            end else begin
                if (alu_start) begin
                    n_starts++;
                    chk("issue_expected", 32'(exp_issue.size() != 0), 1);
                    issued = {alu_op, alu_a, alu_b};
                    if (exp_issue.size() != 0) begin
                        it     = exp_issue.pop_front();
                        issued = {it.op, it.a, it.b};
                        chk("issue_operands", 32'({alu_op, alu_a, alu_b}), 32'(issued));
                    end
                    inflight = 1'b1;
                end else if (inflight && !rsp_valid) begin
                    chk("wait_operands_stable", 32'({alu_op, alu_a, alu_b}), 32'(issued));
                end
                if (rsp_valid) begin
                    inflight = 1'b0;
                    chk("out_alu_zero", 32'({alu_op, alu_a, alu_b}), 0);
                    if (prev_hold) chk("rsp_stable", 32'({rsp_data, rsp_op, rsp_err}), 32'(held));
                    if (rsp_ready) begin
                        chk("rsp_expected", 32'(exp_rsp.size() != 0), 1);
                        if (exp_rsp.size() != 0) begin
                            e = exp_rsp.pop_front();
                            chk("rsp_data", 32'(rsp_data), 32'(e.data));
                            chk("rsp_op", 32'(rsp_op), 32'(e.op));
                            chk("rsp_err", 32'(rsp_err), 32'(e.err));
                        end
                        got.push_back(rsp_data);
                        prev_hold = 1'b0;
                    end else begin
                        prev_hold = 1'b1;
                        held      = {rsp_data, rsp_op, rsp_err};
                    end
                end else begin
                    prev_hold = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        rsp_ready = 1'b0;
        step(3);
        chk("reset_cmd_ready", 32'(cmd_ready), 1);
        chk("reset_alu_bus", 32'({alu_op, alu_a, alu_b, alu_start}), 0);
        chk("reset_rsp", 32'({rsp_valid, rsp_data, rsp_op, rsp_err}), 0);
        chk("reset_count", 32'(fifo_count), 0);
        chk("reset_busy", 32'(busy), 0);
        reset_n = 1'b1;
        step(1);

        // Single ADD: start in N+2, response in N+4
        rsp_ready = 1'b1;
        alu_delay = 1;
        push(4'd1, 8'h12, 8'h34);
        chk("add_n1_start", 32'(alu_start), 0);
        step(1);
        chk("add_n2_start", 32'(alu_start), 1);
        chk("add_n2_operands", 32'({alu_op, alu_a, alu_b}), 32'h11234);
        step(1);
        chk("add_n3_valid", 32'(rsp_valid), 0);
        step(1);
        chk("add_n4_valid", 32'(rsp_valid), 1);
        chk("add_n4_data", 32'(rsp_data), 32'h0046);
        chk("add_n4_op_err", 32'({rsp_op, rsp_err}), 32'b0001_0);
        step(1);
        chk("add_n5_valid", 32'(rsp_valid), 0);

        // Local opcodes respond two cycles after acceptance without the ALU
        s0 = n_starts;
        for (int k = 0; k < 3; k++) begin
            push(local_ops[k], 8'hAA, 8'h55);
            chk("local_n1_valid", 32'(rsp_valid), 0);
            step(1);
            chk("local_n2_valid", 32'(rsp_valid), 1);
            chk("local_n2_data", 32'(rsp_data), 0);
            chk("local_n2_err", 32'(rsp_err), 32'(local_err[k]));
            chk("local_n2_op", 32'(rsp_op), 32'(local_ops[k]));
            step(2);
        end
        chk("local_no_start", n_starts, s0);

        // Five MULs against a stalled response port
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(4'd3, 8'(i), 8'd3);
            if (i == 3) begin
                chk("mul_count_after4", 32'(fifo_count), 3);
                chk("mul_ready_after4", 32'(cmd_ready), 1);
            end
        end
        chk("mul_count_full", 32'(fifo_count), 4);
        chk("mul_ready_full", 32'(cmd_ready), 0);
        cmd_valid = 1'b1;
        cmd_op    = 4'd3;
        cmd_a     = 8'hEE;
        cmd_b     = 8'h01;
        step(2);
        chk("mul_full_blocks", 32'(fifo_count), 4);
        cmd_valid = 1'b0;
        got.delete();
        rsp_ready = 1'b1;
        wait_drain(60);
        chk("mul_rsp_count", got.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk("mul_rsp_value", 32'(got[i]), 32'(i * 3));
        end

        // Slow ALU plus held response
        alu_delay = 6;
        rsp_ready = 1'b0;
        push(4'd1, 8'h20, 8'h05);
        step(7);
        chk("slow_last_wait_valid", 32'(rsp_valid), 0);
        step(1);
        chk("slow_valid", 32'(rsp_valid), 1);
        chk("slow_data", 32'(rsp_data), 32'h0025);
        step(3);
        chk("slow_hold_valid", 32'(rsp_valid), 1);
        chk("slow_hold_data", 32'(rsp_data), 32'h0025);
        rsp_ready = 1'b1;
        step(1);
        chk("slow_released", 32'(rsp_valid), 0);
        alu_delay = 1;

`ifdef ALU_SEQ_TIMEOUT_EN
        alu_never = 1'b1;
        push(4'd1, 8'h01, 8'h02);
        step(16);
        chk("to_last_wait_valid", 32'(rsp_valid), 0);
        step(1);
        chk("to_valid", 32'(rsp_valid), 1);
        chk("to_data", 32'(rsp_data), 32'hDEAD);
        chk("to_err", 32'(rsp_err), 1);
        step(1);
        alu_never = 1'b0;
        alu_delay = 15;
        push(4'd1, 8'h01, 8'h02);
        step(16);
        chk("to15_last_wait_valid", 32'(rsp_valid), 0);
        step(1);
        chk("to15_valid", 32'(rsp_valid), 1);
        chk("to15_data", 32'(rsp_data), 32'h0003);
        chk("to15_err", 32'(rsp_err), 0);
        step(1);
        alu_delay = 1;
`endif

        // Reset while WAITing with two commands queued
        alu_never = 1'b1;
        push(4'd1, 8'h01, 8'h01);
        push(4'd2, 8'h09, 8'h03);
        push(4'd3, 8'h02, 8'h02);
        chk("rst_pre_count", 32'(fifo_count), 2);
        chk("rst_pre_inflight", 32'({alu_op, alu_a, alu_b}), 32'h10101);
        reset_n = 1'b0;
        step(1);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        exp_rsp.delete();
        exp_issue.delete();
        pending   = 0;
        reset_n   = 1'b1;
        alu_never = 1'b0;
        alu_delay = 1;
        step(20);
        chk("post_rst_idle", 32'({busy, rsp_valid}), 0);
        push(4'd1, 8'h07, 8'h08);
        wait_drain(20);

        chk("final_rsp_queue", exp_rsp.size(), 0);
        chk("final_issue_queue", exp_issue.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
